// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and the frame FSM state type shared by the cordic
// stages. The feeder and later stages agree on the chunk width, the chunk
// count per word and the angle width through this package.
package cordic_pkg;

  localparam int CHUNK_W = 2;
  localparam int N_CHUNK = 6;
  localparam int ANG_W   = 12;

  // Frame issue FSM shared by every stage that follows the feeder cadence
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_feeder_if.sv
// cordic_feeder_if: control inputs and serial chunk outputs of the cordic
// feeder.
//   en      - frame issue enable
//   fcw     - phase increment per frame (FCW_W bits)
//   pof     - phase offset added to the angle (ANG_W bits)
//   phs_clr - synchronous phase accumulator clear
//   Rdy     - one-cycle pulse just before chunk 0 of a frame
//   Xout    - X chunks (constant zero, stage 0 uses 1/K)
//   Yout    - Y chunks (constant zero)
//   Aout    - folded angle chunks, LSB chunk first
//   ISout   - quadrant-fold flag of the most recent frame
//   busy    - high while a frame is being sent
// master drives the control side, slave is the feeder itself.
interface cordic_feeder_if
  import cordic_pkg::CHUNK_W;
#(
  parameter int FCW_W = 16,
  parameter int ANG_W = 12
);

  logic               en;
  logic [FCW_W-1:0]   fcw;
  logic [ANG_W-1:0]   pof;
  logic               phs_clr;
  logic               Rdy;
  logic [CHUNK_W-1:0] Xout;
  logic [CHUNK_W-1:0] Yout;
  logic [CHUNK_W-1:0] Aout;
  logic               ISout;
  logic               busy;

  modport master (
    output en, fcw, pof, phs_clr,
    input  Rdy, Xout, Yout, Aout, ISout, busy
  );

  modport slave (
    input  en, fcw, pof, phs_clr,
    output Rdy, Xout, Yout, Aout, ISout, busy
  );

endinterface

// File: rtl/cordic_feeder.sv
// cordic_feeder: phase accumulator plus quadrant fold that serialises one
// folded angle word per frame into 2-bit chunks for a bit-serial CORDIC.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - cordic_feeder_if.slave (en/fcw/pof/phs_clr in,
//           Rdy/Xout/Yout/Aout/ISout/busy out)
module cordic_feeder
  import cordic_pkg::CHUNK_W;
  import cordic_pkg::N_CHUNK;
  import cordic_pkg::state_e;
  import cordic_pkg::ST_IDLE;
  import cordic_pkg::ST_ARM;
  import cordic_pkg::ST_SEND;
#(
  parameter int FCW_W = 16,
  parameter int ANG_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  cordic_feeder_if.slave bus
);

  state_e           state;
  logic [2:0]       cnt;
  logic [FCW_W-1:0] acc;
  logic [ANG_W-1:0] shreg;
  logic             is_pend;
  logic             is_out;

  logic             last_chunk;
  logic             rdy_int;
  logic             send;
  logic [ANG_W-1:0] ang;
  logic             fold;
  logic [ANG_W-1:0] a_word;

  assign last_chunk = (state == ST_SEND) && (cnt == 3'(N_CHUNK - 1));
  // Rdy marks the cycle right before chunk 0: the ARM cycle, or the last
  // chunk of a frame when another frame follows back to back.
  assign rdy_int    = (state == ST_ARM) || (last_chunk && bus.en);
  assign send       = rst_n && (state == ST_SEND);

  // Quadrants 1 and 2 are rotated by half a turn so the CORDIC only sees
  // angles within +-90 deg; the stage output is then sign-inverted via IS.
  assign ang    = acc[FCW_W-1 -: ANG_W] + bus.pof;
  assign fold   = ang[ANG_W-1] ^ ang[ANG_W-2];
  assign a_word = fold ? {~ang[ANG_W-1], ang[ANG_W-2:0]} : ang;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      acc     <= '0;
      shreg   <= '0;
      is_pend <= 1'b0;
      is_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 3'd0;
          if (bus.en) state <= ST_ARM;
        end
        ST_ARM: begin
          cnt   <= 3'd0;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (last_chunk) begin
            cnt <= 3'd0;
            if (!bus.en) state <= ST_IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 3'd0;
        end
      endcase

      // Load the new word at the Rdy edge, otherwise shift out one chunk
      if (rdy_int) begin
        shreg   <= a_word;
        is_pend <= fold;
      end else if (state == ST_SEND) begin
        shreg <= shreg >> CHUNK_W;
      end

      // Clear beats the increment; the word latched this edge still used
      // the old accumulator value.
      if (bus.phs_clr) begin
        acc <= '0;
      end else if (rdy_int) begin
        acc <= acc + bus.fcw;
      end

      // IS is published after chunk 0 so it stays valid for the whole
      // pipeline latency of the downstream stages.
      if (state == ST_SEND && cnt == 3'd0) begin
        is_out <= is_pend;
      end
    end
  end

  assign bus.Rdy   = rst_n && rdy_int;
  assign bus.busy  = send;
  assign bus.Aout  = send ? shreg[CHUNK_W-1:0] : '0;
  assign bus.Xout  = '0;
  assign bus.Yout  = '0;
  assign bus.ISout = is_out;

endmodule

// File: tb/tb_cordic_feeder.sv
// tb_cordic_feeder: directed plus randomised frames for cordic_feeder,
// compared against an arithmetic reference of the phase accumulator and
// the quadrant fold.
module tb_cordic_feeder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   m_acc;
  int   m_is;

  cordic_feeder_if #(.FCW_W(16), .ANG_W(12)) bus ();

  cordic_feeder #(.FCW_W(16), .ANG_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Angle = top 12 bits of the accumulator plus offset, mod one turn.
  // Quadrants 1 and 2 (90..270 deg) are rotated by half a turn.
  task automatic ref_word(input int acc, input int p, output int a, output int is);
    int ang;
    int q;
    ang = ((acc / 16) + p) % 4096;
    q   = ang / 1024;
    if (q == 1 || q == 2) begin
      a  = (ang + 2048) % 4096;
      is = 1;
    end else begin
      a  = ang;
      is = 0;
    end
  endtask

  // Called in a Rdy cycle; runs the six chunk cycles of one frame.
  task automatic frame(input string tag, input bit keep_en);
    int         exp_a;
    int         exp_is;
    int         prev_is;
    logic [11:0] word;
    bit         busy_ok;
    bit         xy_ok;
    bit         rdy_ok;
    ref_word(m_acc, int'(bus.pof), exp_a, exp_is);
    prev_is = m_is;
    m_acc   = bus.phs_clr ? 0 : (m_acc + int'(bus.fcw)) % 65536;
    busy_ok = 1'b1;
    xy_ok   = 1'b1;
    rdy_ok  = 1'b1;
    word    = '0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (k == 0) bus.phs_clr = 1'b0;
      word[2*k +: 2] = bus.Aout;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.Xout !== 2'b00 || bus.Yout !== 2'b00) xy_ok = 1'b0;
      if (k < 5 && bus.Rdy !== 1'b0) rdy_ok = 1'b0;
      check({tag, "/is"}, 32'(bus.ISout), (k == 0) ? 32'(prev_is) : 32'(exp_is));
      if (k == 2) bus.en = keep_en;
      if (k == 5) check({tag, "/rdy_last"}, 32'(bus.Rdy), 32'(keep_en));
    end
    check({tag, "/word"}, 32'(word), 32'(exp_a));
    check({tag, "/busy"}, 32'(busy_ok), 32'd1);
    check({tag, "/xy"}, 32'(xy_ok), 32'd1);
    check({tag, "/rdy_mid"}, 32'(rdy_ok), 32'd1);
    m_is = exp_is;
    if (!keep_en) begin
      tick;
      check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "/idle_rdy"}, 32'(bus.Rdy), 32'd0);
      check({tag, "/idle_aout"}, 32'(bus.Aout), 32'd0);
      check({tag, "/idle_is"}, 32'(bus.ISout), 32'(exp_is));
    end
  endtask

  task automatic start(input string tag);
    bus.en = 1'b1;
    tick;
    check({tag, "/arm_rdy"}, 32'(bus.Rdy), 32'd1);
    check({tag, "/arm_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_acc       = 0;
    m_is        = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.fcw     = '0;
    bus.pof     = '0;
    bus.phs_clr = 1'b0;

    // Reset state, including en held high during reset
    tick;
    tick;
    check("rst/rdy", 32'(bus.Rdy), 32'd0);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/aout", 32'(bus.Aout), 32'd0);
    check("rst/is", 32'(bus.ISout), 32'd0);
    bus.en = 1'b1;
    tick;
    check("rst_en/rdy", 32'(bus.Rdy), 32'd0);
    check("rst_en/busy", 32'(bus.busy), 32'd0);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    tick;

    // Zero phase, single frame
    start("zero");
    frame("zero", 1'b0);

    // Quarter-turn steps, folding on the fifth word
    bus.fcw = 16'h1000;
    start("step");
    for (int f = 0; f < 5; f++) frame($sformatf("step%0d", f), f < 4);
    check("step/acc_model", 32'(m_acc), 32'h5000);
    bus.phs_clr = 1'b1;
    tick;
    bus.phs_clr = 1'b0;
    m_acc = 0;

    // Half-turn offset: word 0 with IS set, held through next chunk 0
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    m_is  = 0;
    m_acc = 0;
    bus.fcw = 16'h0000;
    bus.pof = 12'h800;
    start("half");
    frame("half0", 1'b1);
    frame("half1", 1'b0);

    // Reset at chunk 3 aborts the frame
    bus.pof = 12'h5A3;
    bus.fcw = 16'($urandom);
    start("abort");
    for (int k = 0; k < 4; k++) tick;
    check("abort/is_before", 32'(bus.ISout), 32'd1);
    check("abort/busy_before", 32'(bus.busy), 32'd1);
    rst_n  = 1'b0;
    bus.en = 1'b0;
    tick;
    check("abort/aout", 32'(bus.Aout), 32'd0);
    check("abort/rdy", 32'(bus.Rdy), 32'd0);
    check("abort/busy", 32'(bus.busy), 32'd0);
    check("abort/is", 32'(bus.ISout), 32'd0);
    rst_n = 1'b1;
    m_acc = 0;
    m_is  = 0;
    bus.pof = 12'($urandom);
    bus.fcw = 16'hF000;
    start("after_rst");
    frame("after_rst", 1'b0);

    // Clear in a Rdy cycle: current word uses old acc, next word starts at 0
    bus.fcw = 16'h2000;
    bus.pof = 12'h000;
    start("clr");
    bus.phs_clr = 1'b1;
    frame("clr0", 1'b1);
    frame("clr1", 1'b0);
    check("clr/acc_model", 32'(m_acc), 32'h2000);

    // Randomised bursts of back-to-back frames
    for (int r = 0; r < 4; r++) begin
      int n;
      bus.fcw = 16'($urandom);
      bus.pof = 12'($urandom);
      n = int'($urandom_range(2, 4));
      start($sformatf("rnd%0d", r));
      for (int f = 0; f < n; f++) frame($sformatf("rnd%0d_%0d", r, f), f < n - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_feeder.md
CORDIC_FEEDER -- requirements
Module: cordic_feeder

Interface
REQ-001 SHALL have parameter FCW_W, default 16, meaning phase accumulator and frequency control word width.
REQ-002 SHALL have parameter ANG_W, default 12, meaning angle width; 4096 LSB per full turn, 1024 = 90 deg.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port en, input, 1, frame issue enable.
REQ-006 SHALL have port fcw, input, FCW_W, phase increment per frame.
REQ-007 SHALL have port pof, input, ANG_W, phase offset added to the angle.
REQ-008 SHALL have port phs_clr, input, 1, synchronous accumulator clear.
REQ-009 SHALL have port Rdy, output, 1, one-cycle pulse that starts a downstream 6-chunk load.
REQ-010 SHALL have ports Xout, Yout, and Aout, output, 2 each, serial chunks of X, Y and angle, LSB chunk first.
REQ-011 SHALL have port ISout, output, 1, quadrant-fold flag (result sign inversion).
REQ-012 SHALL have port busy, output, 1, high while a frame is being sent.

Function
REQ-013 SHALL implement an FSM with states IDLE, ARM and SEND, and a chunk counter cnt that counts 0..5 in SEND.
REQ-014 SHALL transition IDLE->ARM at an edge where en=1, ARM->SEND with cnt=0, SEND cnt=5->SEND cnt=0 if en=1, and SEND cnt=5->IDLE if en=0.
REQ-015 SHALL drive Rdy = (state==ARM) | (state==SEND & cnt==5 & en), i.e. the cycle immediately before chunk 0.
REQ-016 SHALL, at the edge ending a Rdy cycle, compute the angle ang = acc[FCW_W-1:FCW_W-ANG_W] + pof, wrapping mod 4096.
REQ-017 SHALL apply the quadrant fold: if ang[11]^ang[10]=1, A = {~ang[11], ang[10:0]} and IS=1; otherwise A = ang and IS=0.
REQ-018 SHALL, at that same edge, latch A into a 12-bit shift register and set acc <= acc + fcw, wrapping, using the fcw sampled at that edge.
REQ-019 SHALL output Aout = A[2k+1:2k] in SEND cycle cnt=k, so chunk 0 appears exactly 1 cycle after Rdy.
REQ-020 SHALL drive Xout = Yout = 2'b00 during SEND, because stage 0 substitutes the 1/K constant.
REQ-021 SHALL drive Aout, Xout and Yout to 2'b00 outside SEND.
REQ-022 SHALL update ISout to the frame's IS only at the edge ending SEND cnt=0, and hold it until the next such edge.
REQ-023 SHALL, as a consequence of REQ-022, keep ISout valid through cnt=0 of the following frame (6 cycles after chunk 0), including the cycle after the last frame.
REQ-024 SHALL give a 6-cycle frame period with en held high, with no gap cycles.
REQ-025 SHALL, when en is dropped mid-frame, complete the current frame and assert no further Rdy.
REQ-026 SHALL, on phs_clr=1, set acc=0 at the next edge.
REQ-027 SHALL, when phs_clr coincides with a Rdy cycle, let the current frame use the pre-clear acc, and have the clear win over the increment.
REQ-028 SHALL drive busy = (state==SEND).

Reset
REQ-029 SHALL, on rst_n=0 at an edge, set state=IDLE, cnt=0, acc=0, shift register=0 and ISout=0, taking effect at that edge.
REQ-030 SHALL hold Rdy=0, Xout/Yout/Aout=0 and busy=0 while rst_n=0.
REQ-031 SHALL abort any frame in progress on reset mid-frame, with no partial chunks emitted after the reset edge.

Structure
REQ-032 SHALL place the constants CHUNK_W=2, N_CHUNK=6, ANG_W=12 and the FSM state enum in shared package cordic_pkg, reused by the cordic stages.
REQ-033 SHALL contain no sub-module; the fold logic SHALL be inline, and the whole block SHALL fit in one module.

Verification
REQ-034 SHALL cover: reset, then en=1, fcw=0, pof=0 -> Rdy one cycle after IDLE, then Aout 00 x6, ISout=0, busy high for 6 cycles.
REQ-035 SHALL cover: fcw=0x1000, en held -> Rdy every 6 cycles; words A=0x000, 0x100 (chunk4=01, rest 00), 0x200, 0x300, then 0xC00 with ISout=1 from cnt=1 of frame 4.
REQ-036 SHALL cover: fcw=0, pof=0x800 -> A=0x000 and ISout=1; ISout rises at the edge after chunk 0 and holds through cnt=0 of the next frame.
REQ-037 SHALL cover: en dropped at cnt=2 -> chunks 3..5 still emitted, no Rdy at cnt=5, IDLE next, ISout held.
REQ-038 SHALL cover: rst_n=0 at cnt=3 -> next cycle Aout=0, Rdy=0, busy=0, ISout=0; after release, the first word has A=pof.
REQ-039 SHALL cover: phs_clr asserted in a Rdy cycle with acc=0xF000 and fcw=0x2000 -> the current word has A=0xF00 (IS=0), the next word has A=0x000.
